// File: rtl/adc_mux_sequencer_pkg.sv
// Shared definitions for the ADC mux sequencer and the downstream axis router.
//  - state_t     : sequencer FSM encoding
//  - AXIS_*      : mux_sel / router axis tags
//  - lowest_axis : lowest enabled axis of a 3-bit X/Y/Z mask (X when the mask is empty)
package adc_mux_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_CONV,
    ST_OUT,
    ST_NEXT
  } state_t;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  function automatic logic [1:0] lowest_axis(input logic [2:0] m);
    if (m[0])      return AXIS_X;
    else if (m[1]) return AXIS_Y;
    else if (m[2]) return AXIS_Z;
    else           return AXIS_X;
  endfunction

endpackage

// File: rtl/adc_mux_sequencer_next_axis_pick.sv
// next_axis_pick: combinational round-robin step over the X/Y/Z mask.
//  mask : enabled axes (bit0=X, bit1=Y, bit2=Z)
//  cur  : axis just finished
//  next : next higher enabled axis, or the lowest enabled axis when none is higher
//  wrap : no higher enabled axis exists, so next wraps to the start of the frame
//  last : cur is the highest enabled axis (frame ends with it)
module next_axis_pick
  import adc_mux_sequencer_pkg::*;
(
  input  logic [2:0] mask,
  input  logic [1:0] cur,
  output logic [1:0] next,
  output logic       wrap,
  output logic       last
);

  // Scan high to low so the final hit is the closest enabled axis above cur.
  always_comb begin
    next = lowest_axis(mask);
    wrap = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) > cur)) begin
        next = 2'(i);
        wrap = 1'b0;
      end
    end
    last = wrap;
  end

endmodule

// File: rtl/adc_mux_sequencer.sv
// adc_mux_sequencer: time-shares one SAR ADC over the X/Y/Z sensor axes.
// For each enabled axis: select mux, settle settle_cyc+1 cycles, pulse conv_start,
// wait for conv_done (abandon after TIMEOUT_CYC cycles), present the code.
//  clk, rst_n            : clock, async active-low reset
//  seq_en                : run level; a running axis always completes before idling
//  axis_mask             : X/Y/Z enables, sampled at each frame start
//  settle_cyc            : extra mux settling cycles
//  err_clr               : clears timeout_err (a same-cycle timeout wins)
//  conv_start            : 1-cycle SAR start pulse
//  conv_done, conv_code  : SAR result strobe and data
//  mux_sel               : current axis tag, stable from SETTLE through OUT
//  adc_code, adc_valid   : captured result and its 1-cycle strobe
//  busy                  : sequencer not idle
//  frame_done            : last enabled axis of the frame finished
//  timeout_err           : sticky conversion timeout flag
module adc_mux_sequencer
  import adc_mux_sequencer_pkg::*;
#(
  parameter int ADC_BITS    = 10,
  parameter int SETTLE_W    = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seq_en,
  input  logic [2:0]          axis_mask,
  input  logic [SETTLE_W-1:0] settle_cyc,
  input  logic                err_clr,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [ADC_BITS-1:0] conv_code,
  output logic [1:0]          mux_sel,
  output logic [ADC_BITS-1:0] adc_code,
  output logic                adc_valid,
  output logic                busy,
  output logic                frame_done,
  output logic                timeout_err
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t              st;
  logic [2:0]          mask_q;
  logic [SETTLE_W-1:0] cnt;
  logic [TMR_W-1:0]    tmr;
  logic [1:0]          nxt_axis;
  logic                nxt_wrap;
  logic                cur_last;

  // Step is taken against the frame's latched mask, never the live input.
  next_axis_pick u_pick (
    .mask (mask_q),
    .cur  (mux_sel),
    .next (nxt_axis),
    .wrap (nxt_wrap),
    .last (cur_last)
  );

  // Strobe outputs are set on the transition into the state they belong to,
  // so they are high exactly while the FSM sits in START / OUT / NEXT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      mask_q      <= 3'b000;
      cnt         <= '0;
      tmr         <= '0;
      mux_sel     <= AXIS_X;
      adc_code    <= '0;
      conv_start  <= 1'b0;
      adc_valid   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      adc_valid  <= 1'b0;
      frame_done <= 1'b0;
      // Clear first; a timeout set later in this block overrides it.
      if (err_clr) timeout_err <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (seq_en && (axis_mask != 3'b000)) begin
            mask_q  <= axis_mask;
            mux_sel <= lowest_axis(axis_mask);
            cnt     <= settle_cyc;
            busy    <= 1'b1;
            st      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            conv_start <= 1'b1;
            st         <= ST_START;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_START: begin
          tmr <= '0;
          st  <= ST_CONV;
        end
        ST_CONV: begin
          if (conv_done) begin
            adc_code  <= conv_code;
            adc_valid <= 1'b1;
            st        <= ST_OUT;
          end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            frame_done  <= cur_last;
            st          <= ST_NEXT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_OUT: begin
          frame_done <= cur_last;
          st         <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!seq_en) begin
            busy <= 1'b0;
            st   <= ST_IDLE;
          end else if (nxt_wrap) begin
            // Frame boundary: the only point where axis_mask is resampled.
            if (axis_mask == 3'b000) begin
              busy <= 1'b0;
              st   <= ST_IDLE;
            end else begin
              mask_q  <= axis_mask;
              mux_sel <= lowest_axis(axis_mask);
              cnt     <= settle_cyc;
              st      <= ST_SETTLE;
            end
          end else begin
            mux_sel <= nxt_axis;
            cnt     <= settle_cyc;
            st      <= ST_SETTLE;
          end
        end
        default: begin
          busy <= 1'b0;
          st   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_mux_sequencer.sv
// Directed bench for adc_mux_sequencer with a behavioural SAR that answers a
// fixed number of cycles after conv_start (optionally muted per axis).
module tb_adc_mux_sequencer;

  localparam int TO      = 16;
  localparam int SAR_LAT = 10;
  localparam int BUDGET  = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seq_en = 1'b0;
  logic [2:0] axis_mask = 3'b000;
  logic [7:0] settle_cyc = 8'd0;
  logic       err_clr = 1'b0;
  logic       conv_start;
  logic       conv_done = 1'b0;
  logic [9:0] conv_code = 10'd0;
  logic [1:0] mux_sel;
  logic [9:0] adc_code;
  logic       adc_valid;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  adc_mux_sequencer #(.ADC_BITS(10), .SETTLE_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .seq_en(seq_en), .axis_mask(axis_mask),
    .settle_cyc(settle_cyc), .err_clr(err_clr), .conv_start(conv_start),
    .conv_done(conv_done), .conv_code(conv_code), .mux_sel(mux_sel),
    .adc_code(adc_code), .adc_valid(adc_valid), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] code_for(input logic [1:0] a);
    case (a)
      2'd0:    return 10'h100;
      2'd1:    return 10'h200;
      2'd2:    return 10'h300;
      default: return 10'h000;
    endcase
  endfunction

  // SAR model: conv_done lands SAR_LAT cycles after the conv_start cycle.
  logic [3:0] sar_mute = 4'b0000;
  int sar_cnt = 0;
  always @(posedge clk) begin
    #1;
    conv_done = 1'b0;
    if (sar_cnt > 0) begin
      sar_cnt--;
      if (sar_cnt == 0) begin
        conv_done = 1'b1;
        conv_code = code_for(mux_sel);
      end
    end
    if (conv_start && !sar_mute[mux_sel]) sar_cnt = SAR_LAT;
  end

  // Monitor (negedge): logs strobes for the main sequence to check.
  int         cyc = 0;
  int         d_cyc = 0;
  int         sy_cyc = 0;
  int         to_cyc = 0;
  logic       to_prev = 1'b0;
  logic       sel1_seen = 1'b0;
  int         cs_cnt = 0;
  logic [1:0] v_axis[$];
  logic [9:0] v_code[$];
  int         v_cyc[$];
  int         v_lat[$];
  logic [1:0] fd_axis[$];

  always @(negedge clk) begin
    cyc++;
    if (adc_valid) begin
      v_axis.push_back(mux_sel);
      v_code.push_back(adc_code);
      v_cyc.push_back(cyc);
      v_lat.push_back(cyc - d_cyc);
    end
    if (conv_done) d_cyc = cyc;
    if (frame_done) fd_axis.push_back(mux_sel);
    if (conv_start) cs_cnt++;
    if (conv_start && mux_sel == 2'd1) sy_cyc = cyc;
    if (timeout_err && !to_prev) to_cyc = cyc;
    to_prev = timeout_err;
    if (busy && mux_sel == 2'd1) sel1_seen = 1'b1;
  end

  task automatic clr_logs();
    v_axis.delete(); v_code.delete(); v_cyc.delete(); v_lat.delete(); fd_axis.delete();
    cs_cnt = 0;
    sel1_seen = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd(input int n, input string tag);
    int k = 0;
    while (fd_axis.size() < n && k < BUDGET) begin tick(1); k++; end
    if (k >= BUDGET) chk({tag, " wait frame_done"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < BUDGET) begin tick(1); k++; end
    if (k >= BUDGET) chk({tag, " wait idle"}, 0, 1);
  endtask

  task automatic wait_cs(input logic [1:0] ax, input string tag);
    int k = 0;
    while (!(conv_start && mux_sel == ax) && k < BUDGET) begin tick(1); k++; end
    if (k >= BUDGET) chk({tag, " wait conv_start"}, 0, 1);
  endtask

  // Cycles from the first cycle showing mux_sel==ax through the conv_start cycle.
  task automatic settle_len(input logic [1:0] ax, input int exp, input string tag);
    int k = 0;
    int n;
    while (mux_sel != ax && k < BUDGET) begin tick(1); k++; end
    if (k >= BUDGET) chk({tag, " wait mux_sel"}, 0, 1);
    n = 1;
    while (!conv_start && n < 100) begin tick(1); n++; end
    chk(tag, n, exp);
  endtask

  initial begin
    // ---- reset values
    tick(3);
    chk("rst busy", busy, 0);
    chk("rst mux_sel", mux_sel, 0);
    chk("rst adc_code", adc_code, 0);
    chk("rst strobes", {conv_start, adc_valid, frame_done}, 0);
    chk("rst timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick(2);

    // ---- 1: XYZ, settle 2, SAR latency 10
    clr_logs();
    axis_mask = 3'b111; settle_cyc = 8'd2; seq_en = 1'b1;
    wait_fd(2, "t1");
    chk("t1 valid count", v_axis.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1 axis[%0d]", i), v_axis[i], i % 3);
      chk($sformatf("t1 code[%0d]", i), v_code[i], (i % 3 + 1) * 'h100);
    end
    chk("t1 axis period", v_cyc[1] - v_cyc[0], 2 + 4 + SAR_LAT);
    chk("t1 done->valid", v_lat[0], 1);
    chk("t1 frame_done axis0", fd_axis[0], 2);
    chk("t1 frame_done axis1", fd_axis[1], 2);
    seq_en = 1'b0;
    wait_idle("t1");

    // ---- 2: X,Z only
    clr_logs();
    axis_mask = 3'b101; seq_en = 1'b1;
    wait_fd(2, "t2");
    chk("t2 valid count", v_axis.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2 axis[%0d]", i), v_axis[i], (i % 2 == 0) ? 0 : 2);
    chk("t2 Y never selected", sel1_seen, 0);
    chk("t2 frame_done after Z", {fd_axis[0], fd_axis[1]}, 4'b1010);
    chk("t2 frame count", fd_axis.size(), 2);
    seq_en = 1'b0;
    wait_idle("t2");

    // ---- 3: settle length
    axis_mask = 3'b010; settle_cyc = 8'd0; seq_en = 1'b1;
    settle_len(2'd1, 2, "t3 settle0 cycles");
    seq_en = 1'b0;
    wait_idle("t3a");
    axis_mask = 3'b011; settle_cyc = 8'd5; seq_en = 1'b1;
    settle_len(2'd0, 7, "t3 settle5 cycles");
    seq_en = 1'b0;
    wait_idle("t3b");

    // ---- 4: Y never answers
    clr_logs();
    sar_mute = 4'b0010; axis_mask = 3'b111; settle_cyc = 8'd1; seq_en = 1'b1;
    wait_fd(1, "t4");
    chk("t4 valid count", v_axis.size(), 2);
    chk("t4 axes", {v_axis[0], v_axis[1]}, 4'b0010);
    chk("t4 Z code", v_code[1], 10'h300);
    chk("t4 timeout_err", timeout_err, 1);
    chk("t4 timeout latency", to_cyc - sy_cyc, TO + 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4 err_clr clears", timeout_err, 0);
    wait_cs(2'd1, "t4b");
    tick(TO);
    chk("t4 flag before retimeout", timeout_err, 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4 set beats clear", timeout_err, 1);
    seq_en = 1'b0;
    wait_idle("t4");
    sar_mute = 4'b0000;

    // ---- 5: seq_en dropped during X CONV
    clr_logs();
    axis_mask = 3'b111; settle_cyc = 8'd2; seq_en = 1'b1;
    wait_cs(2'd0, "t5");
    tick(1);
    seq_en = 1'b0;
    wait_idle("t5");
    chk("t5 valid count", v_axis.size(), 1);
    chk("t5 axis", v_axis[0], 0);
    chk("t5 code", v_code[0], 10'h100);
    chk("t5 no frame_done", fd_axis.size(), 0);
    cs_cnt = 0;
    tick(30);
    chk("t5 busy", busy, 0);
    chk("t5 no conv_start", cs_cnt, 0);

    // ---- 6: reset mid-CONV, SAR answers during reset
    clr_logs();
    seq_en = 1'b1;
    wait_cs(2'd0, "t6");
    tick(3);
    rst_n = 1'b0; seq_en = 1'b0;
    tick(12);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst mux_sel", mux_sel, 0);
    chk("t6 rst adc_code", adc_code, 0);
    chk("t6 rst timeout_err", timeout_err, 0);
    chk("t6 rst strobes", {conv_start, adc_valid, frame_done}, 0);
    rst_n = 1'b1;
    tick(30);
    chk("t6 no valid after reset", v_axis.size(), 0);
    chk("t6 busy", busy, 0);
    chk("t6 conv_start count", cs_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
